// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI-mode-0 PWM register bank: register map,
// frame length and controller states.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop
// producing single-cycle rise/fall strobes in the clk domain.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI-mode-0 slave owning the five PWM control registers.
// Frames are 16 bits MSB first: {wr, addr[6:0], data[7:0]}, committed on CS rise.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ncs,
    input  logic              sclk,
    input  logic              copi,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              wr_done,
    output logic              frame_err
);

    localparam logic [4:0]        CNT_FULL  = 5'(FRAME_BITS);
    localparam logic [4:0]        CNT_OVR   = 5'(FRAME_BITS + 1);
    localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(NUM_REGS);

    logic ncs_lvl,  ncs_rise,  ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .pin(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .pin(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    // Only levels of ncs/copi and the rise of sclk/ncs drive the controller.
    logic unused_edges;
    assign unused_edges = ncs_fall ^ sclk_lvl ^ sclk_fall ^ copi_rise ^ copi_fall;

    state_e                state;
    logic [4:0]            cnt;
    logic [FRAME_BITS-1:0] sreg;

    logic                  frame_wr;
    logic [ADDR_W-1:0]     frame_addr;
    logic [DATA_W-1:0]     frame_data;
    logic                  wr_en;

    assign frame_wr   = sreg[FRAME_BITS-1];
    assign frame_addr = sreg[DATA_W +: ADDR_W];
    assign frame_data = sreg[DATA_W-1:0];

    assign wr_en     = (state == COMMIT) && (cnt == CNT_FULL) && frame_wr
                       && (frame_addr < ADDR_LIM);
    assign wr_done   = wr_en;
    assign frame_err = (state == COMMIT) && (cnt != CNT_FULL);

    // A low synced CS while idle means a fall was seen, possibly during COMMIT,
    // so back-to-back frames with a one-cycle gap are still picked up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ncs_lvl) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sreg  <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        if (cnt < CNT_FULL) begin
                            sreg <= {sreg[FRAME_BITS-2:0], copi_lvl};
                            cnt  <= cnt + 5'd1;
                        end else begin
                            cnt <= CNT_OVR;
                        end
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (wr_en) begin
            case (frame_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                default: ;
            endcase
        end
    end

endmodule
